gpio_uart_bram_bridge: RTL and testbench

//  Fabric-side partner of the MCU GPIO-H0 pin pair. Decodes 8N1 UART command frames that MCU

---
 rtl/gpio_uart_bram_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_gpio_uart_bram_bridge.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_uart_bram_bridge.sv
// UART command bridge between the MCU GPIO-H0 pin pair and a BRAM port (byte write/read).
// Define GPIO_BRIDGE_PARITY_EN for 8E1 framing on both directions; default build is 8N1.
module gpio_uart_bram_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              ppm_clk,
  input  logic              rst_n,
  input  logic              mcu_tx,
  input  logic              mcu_tx_oe_n,
  output logic              mcu_rx,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_wdata,
  input  logic [7:0]        bram_rdata,
  output logic              busy,
  output logic              err_pulse
);
  localparam int CW        = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);
`ifdef GPIO_BRIDGE_PARITY_EN
  localparam int TX_BITS   = 10;
`else
  localparam int TX_BITS   = 9;
`endif
  localparam logic [CW-1:0] HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    CMD_WR = 8'hA5;
  localparam logic [7:0]    CMD_RD = 8'h3C;
  localparam logic [7:0]    ACK    = 8'h5A;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_WR, P_RD, P_RDCAP, P_TX} p_state_t;

  // Bits that follow the start bit on the wire, LSB transmitted first.
  function automatic logic [TX_BITS-1:0] tx_frame(input logic [7:0] d);
`ifdef GPIO_BRIDGE_PARITY_EN
    return {1'b1, ^d, d};
`else
    return {1'b1, d};
`endif
  endfunction

  logic w_line, w_par_ok;
  logic r_sync1, r_sync2, r_rx_prev;

  // A released line (oe_n high) reads as idle so a floating pin never starts a frame.
  assign w_line = mcu_tx_oe_n | mcu_tx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ppm_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= w_line;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  rx_state_t     r_rstate;
  logic [CW-1:0] r_rcnt;
  logic [2:0]    r_rbit;
  logic [7:0]    r_rshift;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid, r_rx_err;
`ifdef GPIO_BRIDGE_PARITY_EN
  logic          r_rpar_bad;
  assign w_par_ok = ~r_rpar_bad;
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge ppm_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate   <= R_IDLE;
      r_rcnt     <= '0;
      r_rbit     <= '0;
      r_rshift   <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
`ifdef GPIO_BRIDGE_PARITY_EN
      r_rpar_bad <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_rstate)
        R_IDLE: if (r_rx_prev && !r_sync2) begin
          r_rcnt   <= '0;
          r_rstate <= R_START;
        end
        R_START: if (r_rcnt == HALF) begin
          r_rcnt   <= '0;
          r_rbit   <= '0;
          r_rstate <= r_sync2 ? R_IDLE : R_DATA;
        end else r_rcnt <= r_rcnt + 1'b1;
        R_DATA: if (r_rcnt == FULL) begin
          r_rcnt   <= '0;
          r_rshift <= {r_sync2, r_rshift[7:1]};
          r_rbit   <= r_rbit + 1'b1;
`ifdef GPIO_BRIDGE_PARITY_EN
          if (r_rbit == 3'd7) r_rstate <= R_PAR;
`else
          if (r_rbit == 3'd7) r_rstate <= R_STOP;
`endif
        end else r_rcnt <= r_rcnt + 1'b1;
`ifdef GPIO_BRIDGE_PARITY_EN
        R_PAR: if (r_rcnt == FULL) begin
          r_rcnt     <= '0;
          r_rpar_bad <= (^r_rshift) ^ r_sync2;
          r_rstate   <= R_STOP;
        end else r_rcnt <= r_rcnt + 1'b1;
`endif
        R_STOP: if (r_rcnt == FULL) begin
          r_rstate <= R_IDLE;
          if (r_sync2 && w_par_ok) begin
            r_rx_valid <= 1'b1;
            r_rx_byte  <= r_rshift;
          end else r_rx_err <= 1'b1;
        end else r_rcnt <= r_rcnt + 1'b1;
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  p_state_t           r_pstate;
  logic               r_is_wr, r_mcu_rx, r_bram_en, r_bram_we, r_busy, r_err_pulse;
  logic [ADDR_W-1:0]  r_bram_addr;
  logic [7:0]         r_bram_wdata;
  logic [TW-1:0]      r_to_cnt;
  logic [TX_BITS-1:0] r_tx_shift;
  logic [3:0]         r_tx_bits;
  logic [CW-1:0]      r_tx_cnt;
  logic [7:0]         w_tx_byte;

  assign w_tx_byte = (r_pstate == P_RDCAP) ? bram_rdata : ACK;

  always_ff @(posedge ppm_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate     <= P_CMD;
      r_is_wr      <= 1'b0;
      r_mcu_rx     <= 1'b1;
      r_bram_en    <= 1'b0;
      r_bram_we    <= 1'b0;
      r_busy       <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_to_cnt     <= '0;
      r_tx_shift   <= '0;
      r_tx_bits    <= '0;
      r_tx_cnt     <= '0;
    end else begin
      r_bram_en   <= 1'b0;
      r_bram_we   <= 1'b0;
      r_err_pulse <= r_rx_err;
      r_busy      <= (r_pstate != P_CMD) || (r_rstate != R_IDLE);
      case (r_pstate)
        P_CMD: if (r_rx_valid) begin
          if (r_rx_byte == CMD_WR || r_rx_byte == CMD_RD) begin
            r_is_wr  <= (r_rx_byte == CMD_WR);
            r_to_cnt <= '0;
            r_pstate <= P_ADDR;
          end else r_err_pulse <= 1'b1;
        end
        P_ADDR, P_DATA: begin
          if (r_rx_err) r_pstate <= P_CMD;
          else if (r_rx_valid) begin
            r_to_cnt <= '0;
            if (r_pstate == P_ADDR) begin
              r_bram_addr <= ADDR_W'(r_rx_byte);
              if (r_is_wr) r_pstate <= P_DATA;
              else begin
                r_bram_en <= 1'b1;
                r_pstate  <= P_RD;
              end
            end else begin
              r_bram_wdata <= r_rx_byte;
              r_bram_en    <= 1'b1;
              r_bram_we    <= 1'b1;
              r_pstate     <= P_WR;
            end
          end else if (r_rstate != R_IDLE) r_to_cnt <= '0;
          else if (r_to_cnt == TW'(TO_CYCLES - 1)) begin
            r_err_pulse <= 1'b1;
            r_pstate    <= P_CMD;
          end else r_to_cnt <= r_to_cnt + 1'b1;
        end
        P_RD: r_pstate <= P_RDCAP;
        // Load and start bit share one edge to hold the ack/reply latency.
        P_WR, P_RDCAP: begin
          r_mcu_rx   <= 1'b0;
          r_tx_shift <= tx_frame(w_tx_byte);
          r_tx_bits  <= 4'(TX_BITS);
          r_tx_cnt   <= '0;
          r_pstate   <= P_TX;
        end
        P_TX: if (r_tx_cnt == FULL) begin
          r_tx_cnt <= '0;
          if (r_tx_bits == 4'd0) r_pstate <= P_CMD;
          else begin
            r_mcu_rx   <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bits  <= r_tx_bits - 1'b1;
          end
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        default: r_pstate <= P_CMD;
      endcase
      if (r_rx_valid && (r_pstate inside {P_WR, P_RD, P_RDCAP, P_TX})) r_err_pulse <= 1'b1;
    end
  end

  assign mcu_rx     = r_mcu_rx;
  assign bram_en    = r_bram_en;
  assign bram_we    = r_bram_we;
  assign bram_addr  = r_bram_addr;
  assign bram_wdata = r_bram_wdata;
  assign busy       = r_busy;
  assign err_pulse  = r_err_pulse;
endmodule

// File: tb/tb_gpio_uart_bram_bridge.sv
// Randomised self-checking bench for gpio_uart_bram_bridge: bit-level UART driver/receiver,
// a behavioural BRAM, and a byte-level memory model predicting every reply.
module tb_gpio_uart_bram_bridge;
  localparam int CPB = 16;
  localparam int TOB = 20;

  logic       clk = 1'b0;
  logic       rst_n, mcu_tx, mcu_tx_oe_n, mcu_rx;
  logic       bram_en, bram_we, busy, err_pulse;
  logic [7:0] bram_addr, bram_wdata, bram_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_uart_bram_bridge #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .TIMEOUT_BITS(TOB)) dut (
    .ppm_clk(clk), .rst_n(rst_n), .mcu_tx(mcu_tx), .mcu_tx_oe_n(mcu_tx_oe_n),
    .mcu_rx(mcu_rx), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy), .err_pulse(err_pulse)
  );

  // Physical BRAM attached to the port, and the reference copy of what it should hold.
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata     <= mem[bram_addr];
    end
  end

  int cyc = 0;
  int en_cnt = 0, we_cnt = 0, err_cnt = 0, en_long = 0, err_long = 0, we_orphan = 0, t_en = 0;
  logic [7:0] last_eaddr, last_waddr, last_wdata;
  logic prev_en = 1'b0, prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_en  <= bram_en;
    prev_err <= err_pulse;
    if (bram_en === 1'b1) begin
      en_cnt     <= en_cnt + 1;
      last_eaddr <= bram_addr;
      t_en       <= cyc;
      if (prev_en) en_long <= en_long + 1;
      if (bram_we === 1'b1) begin
        we_cnt     <= we_cnt + 1;
        last_waddr <= bram_addr;
        last_wdata <= bram_wdata;
      end
    end
    if (bram_we === 1'b1 && bram_en !== 1'b1) we_orphan <= we_orphan + 1;
    if (err_pulse === 1'b1) begin
      err_cnt <= err_cnt + 1;
      if (prev_err) err_long <= err_long + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit hold);
    mcu_tx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mcu_tx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef GPIO_BRIDGE_PARITY_EN
    mcu_tx = ^b;
    repeat (CPB) @(negedge clk);
`endif
    mcu_tx = stop_v;
    if (hold || !stop_v) repeat (CPB) @(negedge clk);
    mcu_tx = 1'b1;
  endtask

`ifdef GPIO_BRIDGE_PARITY_EN
  task automatic send_badpar(input logic [7:0] b);
    mcu_tx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mcu_tx = b[i];
      repeat (CPB) @(negedge clk);
    end
    mcu_tx = ~(^b);
    repeat (CPB) @(negedge clk);
    mcu_tx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask
`endif

  // Waits up to budget cycles for a start bit, then samples the reply at bit centres.
  task automatic recv_reply(input int budget, output bit seen, output bit ok,
                            output logic [7:0] b, output int t_start, output logic busy_s);
    int n = 0;
    seen = 1'b0; ok = 1'b0; b = '0; t_start = 0; busy_s = 1'b0;
    while (mcu_rx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mcu_rx !== 1'b0) return;
    seen = 1'b1;
    t_start = cyc;
    busy_s = busy;
    repeat (CPB / 2) @(negedge clk);
    ok = (mcu_rx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = mcu_rx;
    end
`ifdef GPIO_BRIDGE_PARITY_EN
    repeat (CPB) @(negedge clk);
    if (mcu_rx !== ^b) ok = 1'b0;
`endif
    repeat (CPB) @(negedge clk);
    if (mcu_rx !== 1'b1) ok = 1'b0;
  endtask

  task automatic do_txn(input bit is_wr, input logic [7:0] addr, input logic [7:0] data,
                        input string tag);
    int en0, we0, err0, t0;
    bit seen, ok;
    logic [7:0] rep, exp;
    logic bs;
    en0 = en_cnt; we0 = we_cnt; err0 = err_cnt;
    exp = is_wr ? 8'h5A : ref_mem[addr];
    if (is_wr) begin
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(addr, 1'b1, 1'b1);
      send_byte(data, 1'b1, 1'b0);
      ref_mem[addr] = data;
    end else begin
      send_byte(8'h3C, 1'b1, 1'b1);
      send_byte(addr, 1'b1, 1'b0);
    end
    recv_reply(8 * CPB, seen, ok, rep, t0, bs);
    check($sformatf("%s_reply_seen", tag), seen, 1);
    check($sformatf("%s_reply_frame", tag), ok, 1);
    check($sformatf("%s_reply", tag), rep, exp);
    check($sformatf("%s_busy_in_reply", tag), bs, 1);
    check($sformatf("%s_en_pulses", tag), en_cnt - en0, 1);
    check($sformatf("%s_we_pulses", tag), we_cnt - we0, is_wr ? 1 : 0);
    check($sformatf("%s_latency", tag), t0 - t_en, is_wr ? 1 : 2);
    check($sformatf("%s_addr", tag), last_eaddr, addr);
    if (is_wr) check($sformatf("%s_wdata", tag), last_wdata, data);
    check($sformatf("%s_no_err", tag), err_cnt - err0, 0);
    repeat (CPB + 4) @(negedge clk);
    check($sformatf("%s_busy_idle", tag), busy, 0);
  endtask

  initial begin
    int en0, err0, t0;
    bit seen, ok;
    logic [7:0] rep;
    logic bs;
    mcu_tx = 1'b1;
    mcu_tx_oe_n = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_mcu_rx", mcu_rx, 1);
    check("rst_busy", busy, 0);
    check("rst_bram_en", bram_en, 0);
    check("rst_bram_we", bram_we, 0);
    check("rst_err", err_pulse, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_wdata", bram_wdata, 0);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);

    do_txn(1'b1, 8'h12, 8'hC3, "wr12");
    do_txn(1'b0, 8'h12, 8'h00, "rd12");

    // Unknown command byte: one error, no access, no reply.
    en0 = en_cnt; err0 = err_cnt;
    send_byte(8'h77, 1'b1, 1'b1);
    recv_reply(4 * CPB, seen, ok, rep, t0, bs);
    check("badcmd_no_reply", seen, 0);
    check("badcmd_err", err_cnt - err0, 1);
    check("badcmd_no_en", en_cnt - en0, 0);
    check("badcmd_busy_idle", busy, 0);
    do_txn(1'b1, 8'h00, 8'h01, "wr00");

    // Inter-byte timeout after the address byte of a write.
    en0 = en_cnt; err0 = err_cnt;
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h40, 1'b1, 1'b1);
    repeat (TOB * CPB + 1 + CPB) @(negedge clk);
    check("timeout_err", err_cnt - err0, 1);
    check("timeout_no_en", en_cnt - en0, 0);
    check("timeout_busy_idle", busy, 0);
    do_txn(1'b0, 8'h40, 8'h00, "rd40");

    // Framing error on the address byte returns the parser to command state.
    en0 = en_cnt; err0 = err_cnt;
    send_byte(8'hA5, 1'b1, 1'b1);
    send_byte(8'h40, 1'b0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    check("frame_err", err_cnt - err0, 1);
    check("frame_no_en", en_cnt - en0, 0);
    do_txn(1'b0, 8'h12, 8'h00, "rd12_after_frame");

    // Quarter-bit glitch and a released line are both ignored.
    en0 = en_cnt; err0 = err_cnt;
    mcu_tx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    mcu_tx = 1'b1;
    recv_reply(3 * CPB, seen, ok, rep, t0, bs);
    check("glitch_no_reply", seen, 0);
    mcu_tx_oe_n = 1'b1;
    mcu_tx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    mcu_tx = 1'b1;
    mcu_tx_oe_n = 1'b0;
    repeat (CPB) @(negedge clk);
    check("glitch_oe_no_err", err_cnt - err0, 0);
    check("glitch_oe_no_en", en_cnt - en0, 0);
    check("glitch_oe_busy", busy, 0);

`ifdef GPIO_BRIDGE_PARITY_EN
    en0 = en_cnt; err0 = err_cnt;
    send_byte(8'hA5, 1'b1, 1'b1);
    send_badpar(8'h22);
    recv_reply(4 * CPB, seen, ok, rep, t0, bs);
    check("par_no_reply", seen, 0);
    check("par_err", err_cnt - err0, 1);
    check("par_no_en", en_cnt - en0, 0);
    do_txn(1'b0, 8'h22, 8'h00, "rd22_after_par");
`endif

    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, d;
      a = {4'h8, 4'($urandom)};
      d = 8'($urandom);
      do_txn(1'($urandom), a, d, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
    end

    // Reset asserted in the middle of a reply start bit.
    send_byte(8'h3C, 1'b1, 1'b1);
    send_byte(8'h12, 1'b1, 1'b0);
    recv_reply(0, seen, ok, rep, t0, bs);
    for (int n = 0; n < 8 * CPB && mcu_rx !== 1'b0; n++) @(negedge clk);
    repeat (CPB / 2) @(negedge clk);
    check("midreply_line_low", mcu_rx, 0);
    check("midreply_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_mcu_rx", mcu_rx, 1);
    check("rst_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("post_rst_line_idle", mcu_rx, 1);
    do_txn(1'b0, 8'h12, 8'h00, "rd12_after_rst");

    check("en_single_cycle", en_long, 0);
    check("err_single_cycle", err_long, 0);
    check("we_only_with_en", we_orphan, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
